// File: rtl/cms_ctrl_scheduler_if.sv
// Requester-side handshake bundle for cms_ctrl_scheduler.
// Requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH] of req_addr and the matching
// slice of req_wdata.
//   req_valid : per-requester write request
//   req_addr  : flattened request addresses
//   req_wdata : flattened request data
//   req_ready : one-hot (or zero) accept back to the requesters
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface cms_ctrl_scheduler_if #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = `DATA_WIDTH
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_ready;

    modport master (output req_valid, output req_addr, output req_wdata, input req_ready);
    modport slave  (input req_valid, input req_addr, input req_wdata, output req_ready);
endinterface

// File: rtl/cms_ctrl_scheduler.sv
// Round-robin scheduler that plays requester writes into the edge-triggered CMS control port
// as setup / write-enable-high / gap strobes.
//   clk, rst_n        : clock, asynchronous active-low reset
//   req               : requester handshake bundle (slave side)
//   ctrl_addr         : registered control address (held between handshakes)
//   ctrl_wdata        : registered control data (held between handshakes)
//   ctrl_write_enable : registered write strobe
//   busy              : FSM is not idle
//   last_grant        : index of the most recently accepted requester
//   write_count       : completed strobes, wraps at 16 bits
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module cms_ctrl_scheduler #(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned ADDR_WIDTH     = `ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = `DATA_WIDTH,
    parameter int unsigned WE_HIGH_CYCLES = 1,
    parameter int unsigned GAP_CYCLES     = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    cms_ctrl_scheduler_if.slave        req,
    output logic [ADDR_WIDTH-1:0]      ctrl_addr,
    output logic [DATA_WIDTH-1:0]      ctrl_wdata,
    output logic                       ctrl_write_enable,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [15:0]                write_count
);
    localparam int unsigned GrantW = $clog2(NUM_REQ);
    localparam int unsigned CntMax = (WE_HIGH_CYCLES > GAP_CYCLES) ? WE_HIGH_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] WeLoad  = CntW'(WE_HIGH_CYCLES - 1);
    localparam logic [CntW-1:0] GapLoad = CntW'(GAP_CYCLES - 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSetup  = 2'd1;
    localparam logic [1:0] StStrobe = 2'd2;
    localparam logic [1:0] StGap    = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [GrantW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [GrantW-1:0]     grant_q, grant_d;
    logic [15:0]           write_count_q, write_count_d;

    logic                  grant_found;
    logic [GrantW-1:0]     grant_idx;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic [DATA_WIDTH-1:0] grant_wdata;
    logic                  hi_found;
    int                    lo_sel, hi_sel;
    logic [NUM_REQ-1:0]    ready;

    // Round-robin search: the lowest valid index at or above rr_ptr wins; if none exists the
    // search wraps and the lowest valid index overall wins.
    always_comb begin
        grant_found = 1'b0;
        hi_found    = 1'b0;
        lo_sel      = 0;
        hi_sel      = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req.req_valid[i]) begin
                grant_found = 1'b1;
                lo_sel      = i;
                if (i >= int'(rr_ptr_q)) begin
                    hi_found = 1'b1;
                    hi_sel   = i;
                end
            end
        end
        grant_idx   = hi_found ? GrantW'(hi_sel) : GrantW'(lo_sel);
        grant_addr  = '0;
        grant_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == GrantW'(i)) begin
                grant_addr  = req.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                grant_wdata = req.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Gated by rst_n so no requester sees an accept while reset is asserted.
    always_comb begin
        ready = '0;
        if (rst_n && (state_q == StIdle) && grant_found) begin
            ready[grant_idx] = 1'b1;
        end
    end
    assign req.req_ready = ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        write_count_d = write_count_q;
        case (state_q)
            StIdle: begin
                if (grant_found) begin
                    addr_d   = grant_addr;
                    wdata_d  = grant_wdata;
                    grant_d  = grant_idx;
                    rr_ptr_d = (grant_idx == GrantW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                cnt_d   = WeLoad;
                we_d    = 1'b1;
                state_d = StStrobe;
            end
            StStrobe: begin
                if (cnt_q == '0) begin
                    we_d          = 1'b0;
                    write_count_d = write_count_q + 16'd1;
                    cnt_d         = GapLoad;
                    state_d       = StGap;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            write_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            write_count_q <= write_count_d;
        end
    end

    assign ctrl_addr         = addr_q;
    assign ctrl_wdata        = wdata_q;
    assign ctrl_write_enable = we_q;
    assign busy              = (state_q != StIdle);
    assign last_grant        = grant_q;
    assign write_count       = write_count_q;
endmodule

// File: doc/cms_ctrl_scheduler.md
# cms_ctrl_scheduler

Sequences and arbitrates configuration writes into the continuous monitoring system's control port (`ctrl_addr`, `ctrl_wdata`, `ctrl_write_enable`). Several requesters, such as the host register bridge, a trigger sequencer and a debug port, submit writes over valid/ready handshakes. The scheduler picks one requester by round-robin. It then plays the write out as a strobe that the edge-triggered control port accepts: stable address/data first, then a write-enable high phase, then a mandatory low gap. It sits directly in front of the `continuous_monitoring_system` instance, which is built with `CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED=1`.

## Interface
Parameters:
- `NUM_REQ`, default 3: number of requesters, from 2 to 8.
- `ADDR_WIDTH`, default `` `ADDR_WIDTH ``: control address width.
- `DATA_WIDTH`, default `` `DATA_WIDTH ``: control data width.
- `WE_HIGH_CYCLES`, default 1: cycles `ctrl_write_enable` is held high, at least 1.
- `GAP_CYCLES`, default 1: cycles `ctrl_write_enable` is held low after the strobe, at least 1.

Ports:
- `clk`, in, 1: the single clock. All logic is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, `NUM_REQ`: per-requester write request.
- `req_addr`, in, `NUM_REQ*ADDR_WIDTH`: flattened addresses; requester i occupies slice `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_wdata`, in, `NUM_REQ*DATA_WIDTH`: flattened data, sliced the same way.
- `req_ready`, out, `NUM_REQ`: one-hot (or zero) accept.
- `ctrl_addr`, out, `ADDR_WIDTH`: registered, to the CMS.
- `ctrl_wdata`, out, `DATA_WIDTH`: registered, to the CMS.
- `ctrl_write_enable`, out, 1: registered, to the CMS.
- `busy`, out, 1: high whenever the FSM is not in IDLE.
- `last_grant`, out, `$clog2(NUM_REQ)`: index of the most recently accepted requester.
- `write_count`, out, 16: number of completed strobes.

## Operation
- FSM states: IDLE, SETUP, STROBE, GAP.
- **IDLE**
  - Grant is combinational: the first requester with `req_valid` set, searching upward from pointer `rr_ptr` with wrap-around.
  - `req_ready[g]=1` only for the granted index g, and only in IDLE. `req_ready` is all zero in every other state.
  - A handshake is `req_valid[g] & req_ready[g]`. On a handshake:
    - latch slice g of `req_addr`/`req_wdata` into `ctrl_addr`/`ctrl_wdata`;
    - set `last_grant<=g` and `rr_ptr<=(g+1) mod NUM_REQ`;
    - go to SETUP.
  - With no valid request, stay in IDLE and leave `rr_ptr` unchanged.
- **SETUP**: lasts 1 cycle with `ctrl_write_enable=0` and addr/data stable, then go to STROBE.
- **STROBE**
  - `ctrl_write_enable=1` for exactly `WE_HIGH_CYCLES` cycles, counted by a down-counter.
  - On the last STROBE cycle, `write_count` increments (16-bit, wraps 0xFFFF to 0x0000). The FSM then goes to GAP.
- **GAP**: `ctrl_write_enable=0` for exactly `GAP_CYCLES` cycles, then return to IDLE.
- `ctrl_addr`/`ctrl_wdata` are held from the handshake until the next handshake. They are never changed while `ctrl_write_enable=1`.
- Requesters must hold `req_valid`/addr/data until accepted. A request that is dropped before acceptance is ignored, with no side effects.
- **Reset values** (asynchronous, take effect immediately on `rst_n` low, mid-write included):
  - state=IDLE, `ctrl_write_enable=0`, `ctrl_addr=0`, `ctrl_wdata=0`;
  - `rr_ptr=0`, `last_grant=0`, `write_count=0`, `busy=0`;
  - while `rst_n=0`: `req_ready=0`.
- A write interrupted by reset is lost and is not counted. The requester sees no handshake for any later re-request until a normal IDLE accept occurs.

## Timing
- Handshake at cycle T (in IDLE):
  - T+1: SETUP; new addr/data are visible on the outputs.
  - T+2 to T+1+`WE_HIGH_CYCLES`: write enable high.
  - The following `GAP_CYCLES` cycles: low.
  - IDLE at T+2+`WE_HIGH_CYCLES`+`GAP_CYCLES`; the earliest next handshake is in that cycle.
- With default parameters, back-to-back handshakes are spaced 4 cycles apart and `ctrl_write_enable` toggles 0,1,0,0 within each write.
- `write_count` updates on the clock edge that ends the last STROBE cycle.
- `busy` is registered from the state, so it reads 1 from T+1 through the last GAP cycle.
- Simultaneous requests are served in round-robin order. No requester waits more than `NUM_REQ-1` writes.

## Test plan
- **Single write:** req 0 sends addr=3, data=0xA5 at T. Expect `ctrl_addr=3`/`ctrl_wdata=0xA5` at T+1, `ctrl_write_enable`=1 only at T+2, `write_count=1` after T+2, and `busy` high for T+1 to T+3.
- **Round-robin with all requesters:** all 3 requesters hold valid continuously from reset. Expect grant order 0,1,2,0,1,2 with handshakes every 4 cycles, and `last_grant` following that order.
- **Stability under contention:** req 2 is valid while req 0 is mid-STROBE. Expect `req_ready` all zero until IDLE, and `ctrl_addr`/`ctrl_wdata` unchanged while the enable is high.
- **Reset mid-STROBE:** with `WE_HIGH_CYCLES=3`, assert `rst_n=0` during the second strobe cycle. Expect `ctrl_write_enable=0` immediately (before the next edge), all outputs at their reset values, and `write_count=0`.
- **Counter wrap and strobe width:** force 65 536 writes, or preload the counter via a bench `force`. Expect the count to wrap to 0x0000. With `WE_HIGH_CYCLES=3` and `GAP_CYCLES=2`, measure 3 high cycles, 2 gap cycles and 7-cycle handshake spacing.
